// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with overlap/non-overlap modes and a saturating hit counter.
// Match is registered, so it is visible one cycle after the final bit is presented.
module seq_detect_prog #(
   parameter int                 MAX_LEN     = 8,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_0110,
   parameter int                 RST_LEN     = 4,
   parameter int                 CNT_W       = 8,
   localparam int                LW          = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in,
   input  logic               overlap,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               clr_count,
   output logic               match,
   output logic [CNT_W-1:0]   match_count
);

   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [MAX_LEN-1:0] nh, len_mask;
   logic [LW-1:0]      len_q, len_d;
   logic [LW-1:0]      fill_q, fill_d, fill_sat, cfg_len_c;
   logic [LW:0]        fill_inc;
   logic               match_q, match_d;
   logic               hit;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   always_comb begin
      nh = {hist_q[MAX_LEN-2:0], in};
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len_q));
      end
      fill_inc = {1'b0, fill_q} + (LW+1)'(1);
      fill_sat = (fill_inc > (LW+1)'(MAX_LEN)) ? LW'(MAX_LEN) : fill_inc[LW-1:0];
      // fill guards against matching on bits from before the last restart
      hit = in_valid && !cfg_load && (fill_inc >= {1'b0, len_q}) &&
            ((nh & len_mask) == (pat_q & len_mask));

      if (cfg_len == '0) begin
         cfg_len_c = LW'(1);
      end else if (cfg_len > LW'(MAX_LEN)) begin
         cfg_len_c = LW'(MAX_LEN);
      end else begin
         cfg_len_c = cfg_len;
      end
   end

   always_comb begin
      pat_d   = pat_q;
      len_d   = len_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      match_d = 1'b0;

      if (cfg_load) begin
         pat_d  = cfg_pattern;
         len_d  = cfg_len_c;
         hist_d = '0;
         fill_d = '0;
         cnt_d  = '0;
      end else begin
         if (in_valid) begin
            hist_d = nh;
            fill_d = (hit && !overlap) ? '0 : fill_sat;
         end
         if (clr_count) begin
            cnt_d = '0;
         end
         if (hit) begin
            match_d = 1'b1;
            if (clr_count) begin
               cnt_d = CNT_W'(1);
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q   <= RST_PATTERN;
         len_q   <= LW'(RST_LEN);
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pat_q   <= pat_d;
         len_q   <= len_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
      end
   end

   assign match       = match_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed plan steps plus random traffic against a queue-based model.
module tb_seq_detect_prog;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_b, overlap, cfg_load, clr_count;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       match, match2;
   logic [7:0] match_count;
   logic [1:0] match_count2;

   int checks = 0;
   int fails  = 0;

   // model: bits eligible for a match since the last restart or non-overlap hit
   bit         q[$];
   logic [7:0] m_pat;
   int         m_len;
   int         m_cnt, m_cnt2;
   bit         m_match;

   always #5 clk = ~clk;

   seq_detect_prog #(.MAX_LEN(8), .RST_PATTERN(8'b0000_0110), .RST_LEN(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_b), .overlap(overlap),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .clr_count(clr_count), .match(match), .match_count(match_count)
   );

   seq_detect_prog #(.MAX_LEN(8), .RST_PATTERN(8'b0000_0110), .RST_LEN(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_b), .overlap(overlap),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .clr_count(clr_count), .match(match2), .match_count(match_count2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pat   = 8'b0000_0110;
      m_len   = 4;
      m_cnt   = 0;
      m_cnt2  = 0;
      m_match = 0;
   endtask

   task automatic count_hit(input bit clr);
      if (clr) begin
         m_cnt  = 1;
         m_cnt2 = 1;
      end else begin
         if (m_cnt < 255) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end
   endtask

   task automatic model_step(input bit v, input bit b, input bit ov, input bit ld,
                             input logic [7:0] p, input int l, input bit clr);
      bit hit;
      if (ld) begin
         m_pat   = p;
         m_len   = (l == 0) ? 1 : (l > 8) ? 8 : l;
         q.delete();
         m_cnt   = 0;
         m_cnt2  = 0;
         m_match = 0;
      end else if (v) begin
         q.push_back(b);
         hit = (q.size() >= m_len);
         for (int i = 0; i < m_len && hit; i++) begin
            if (q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 0;
         end
         m_match = hit;
         if (hit) count_hit(clr);
         else if (clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
         end
         if (hit && !ov) q.delete();
         while (q.size() > 8) void'(q.pop_front());
      end else begin
         m_match = 0;
         if (clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
         end
      end
   endtask

   task automatic step(input bit v, input bit b, input bit ov, input bit ld,
                       input logic [7:0] p, input int l, input bit clr);
      in_valid    = v;
      in_b        = b;
      overlap     = ov;
      cfg_load    = ld;
      cfg_pattern = p;
      cfg_len     = l[3:0];
      clr_count   = clr;
      @(posedge clk);
      #1;
      model_step(v, b, ov, ld, p, l, clr);
      chk("match", {31'd0, match}, {31'd0, m_match});
      chk("count", {24'd0, match_count}, m_cnt);
      chk("match_w2", {31'd0, match2}, {31'd0, m_match});
      chk("count_w2", {30'd0, match_count2}, m_cnt2);
      in_valid  = 0;
      cfg_load  = 0;
      clr_count = 0;
   endtask

   task automatic send(input bit b, input bit ov);
      step(1, b, ov, 0, 8'h00, 0, 0);
   endtask

   task automatic gap();
      step(0, 0, 1, 0, 8'h00, 0, 0);
   endtask

   task automatic load(input logic [7:0] p, input int l);
      step(0, 0, 1, 1, p, l, 0);
   endtask

   // rst rises between edges; outputs must clear without waiting for a clock
   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_match", {31'd0, match}, 32'd0);
      chk("rst_count", {24'd0, match_count}, 32'd0);
      chk("rst_count_w2", {30'd0, match_count2}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit stream7[7];
      int r, l;
      stream7 = '{0, 1, 1, 0, 1, 1, 0};
      rst = 1'b0; in_valid = 0; in_b = 0; overlap = 1; cfg_load = 0;
      cfg_pattern = 0; cfg_len = 0; clr_count = 0;
      #2;
      do_reset();

      // default pattern 0110, overlapping
      foreach (stream7[i]) send(stream7[i], 1);
      chk("plan_default_cnt", {24'd0, match_count}, 32'd2);

      // async reset mid-pattern, then a trailing 0 must not complete a hit
      send(0, 1); send(1, 1); send(1, 1);
      do_reset();
      send(0, 1);
      chk("plan_post_rst_match", {31'd0, match}, 32'd0);

      // non-overlapping
      do_reset();
      foreach (stream7[i]) send(stream7[i], 0);
      chk("plan_nonovl_cnt", {24'd0, match_count}, 32'd1);

      // gaps between valid bits
      do_reset();
      send(0, 1); gap(); gap(); gap();
      send(1, 1); gap(); gap(); gap();
      send(1, 1); gap(); gap(); gap();
      send(0, 1);
      chk("plan_gap_match", {31'd0, match}, 32'd1);
      gap();
      chk("plan_gap_pulse_end", {31'd0, match}, 32'd0);

      // mid-stream reprogram to an 8-bit pattern
      send(0, 1); send(1, 1);
      load(8'b1010_0111, 8);
      send(1, 1); send(0, 1); send(1, 1); send(0, 1);
      send(0, 1); send(1, 1); send(1, 1); send(1, 1);
      chk("plan_reprog_match", {31'd0, match}, 32'd1);
      chk("plan_reprog_cnt", {24'd0, match_count}, 32'd1);

      // length 0 clamps to 1
      load(8'b0000_0001, 0);
      send(1, 0); send(0, 0); send(1, 0);
      chk("plan_len0_cnt", {24'd0, match_count}, 32'd2);

      // 2-bit counter saturation and clear coincident with a hit
      load(8'b0000_0001, 1);
      for (int i = 0; i < 5; i++) begin
         send(1, 1);
         chk("plan_sat_cnt", {30'd0, match_count2}, (i < 3) ? i + 1 : 3);
      end
      step(1, 1, 1, 0, 8'h00, 0, 1);
      chk("plan_clr_hit_cnt", {30'd0, match_count2}, 32'd1);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            l = (r < 1) ? $urandom_range(0, 15) : $urandom_range(1, 4);
            load(8'($urandom), l);
         end else if (r < 5) begin
            do_reset();
         end else begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 0, 8'h00, 0,
                 (r >= 97));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
